// File: rtl/sel_seq_pkg.sv
// Shared types for the select sequencer: command modes, FSM states, command layout.
// Ports: none (package only).
// Helper functions decode a mode into the two select bits.
package sel_seq_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SEL1 = 2'd1,
    SEL2 = 2'd2,
    BOTH = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 4;

  // Command as stored in the FIFO at the default length width.
  typedef struct packed {
    mode_t                mode;
    logic [CNT_W_DEF-1:0] len;
  } cmd_t;

  function automatic logic mode_sel1(mode_t m);
    return (m == SEL1) || (m == BOTH);
  endfunction

  function automatic logic mode_sel2(mode_t m);
    return (m == SEL2) || (m == BOTH);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with pointer-compare full/empty and a flop-array head.
// Ports: push/din write the tail, pop advances the head, dout shows the head entry,
//        full/empty from log2(DEPTH)+1-bit pointers; rst clears the pointers asynchronously.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sel_sequencer.sv
// Plays queued timed select commands onto registered sel1/sel2, back-to-back, low when idle.
// Ports: cmd_valid/cmd_ready/cmd_mode/cmd_len command input (ready = FIFO not full),
//        sel1/sel2 registered selects, busy while playing, done in each command's final cycle.
module sel_sequencer
  import sel_seq_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             sel1,
  output logic             sel2,
  output logic             busy,
  output logic             done
);

  // Same layout as cmd_t, with the length field following CNT_W.
  typedef struct packed {
    mode_t            mode;
    logic [CNT_W-1:0] len;
  } cmd_w_t;

  cmd_w_t           wr_cmd;
  cmd_w_t           head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sel1_n, sel2_n;

  assign wr_cmd.mode = mode_t'(cmd_mode);
  assign wr_cmd.len  = cmd_len;
  assign cmd_ready   = !full;
  assign push        = cmd_valid && !full;

  sync_fifo #(
    .W     ($bits(cmd_w_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel1  <= 1'b0;
      sel2  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel1  <= sel1_n;
      sel2  <= sel2_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel1_n  = sel1;
    sel2_n  = sel2;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        sel1_n = 1'b0;
        sel2_n = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          cnt_n   = head.len;
          sel1_n  = mode_sel1(head.mode);
          sel2_n  = mode_sel2(head.mode);
          state_n = PLAY;
        end
      end
      PLAY: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!empty) begin
          // Reload at the final edge so the next command starts with no gap.
          pop    = 1'b1;
          cnt_n  = head.len;
          sel1_n = mode_sel1(head.mode);
          sel2_n = mode_sel2(head.mode);
        end else begin
          sel1_n  = 1'b0;
          sel2_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == PLAY);
  assign done = (state == PLAY) && (cnt == '0);

endmodule

// File: tb/tb_sel_sequencer.sv
module tb_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [3:0] cmd_len = 4'd0;
  logic       sel1, sel2, busy, done;

  int total = 0;
  int bad   = 0;

  logic [4:0] outv;   // {sel1, sel2, busy, done, cmd_ready}
  assign outv = {sel1, sel2, busy, done, cmd_ready};

  sel_sequencer #(.CNT_W(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_len   (cmd_len),
    .sel1      (sel1),
    .sel2      (sel2),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_len   = l;
  endtask

  logic [4:0] exp_q [$];
  logic [1:0] bm [4];
  logic [3:0] bl [4];
  logic [1:0] rm [10];
  logic [3:0] rl [10];
  logic [3:0] sexp [$];
  int         idx;
  logic       acc;
  int         ncyc;
  logic [3:0] want;

  initial begin
    // Reset state and idle with no commands.
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("rst_idle%0d", i), outv, 5'b00001);
      step();
    end

    // Single command: mode 1, len 3.
    drive(2'd1, 4'd3);
    step();
    cmd_valid = 1'b0;
    exp_q = '{5'b00001, 5'b10101, 5'b10101, 5'b10101, 5'b10111, 5'b00001, 5'b00001};
    foreach (exp_q[i]) begin
      chk($sformatf("single%0d", i), outv, exp_q[i]);
      step();
    end

    // Back-to-back: (2,0), (3,1), (0,2).
    drive(2'd2, 4'd0);
    step();
    chk("b2b_a", outv, 5'b00001);
    drive(2'd3, 4'd1);
    step();
    chk("b2b_b", outv, 5'b01111);
    drive(2'd0, 4'd2);
    step();
    chk("b2b_c", outv, 5'b11101);
    cmd_valid = 1'b0;
    exp_q = '{5'b11111, 5'b00101, 5'b00101, 5'b00111, 5'b00001};
    foreach (exp_q[i]) begin
      step();
      chk($sformatf("b2b_t%0d", i), outv, exp_q[i]);
    end
    step();

    // Backpressure: valid held high, first command len 15, DEPTH 2.
    bm = '{2'd1, 2'd2, 2'd3, 2'd0};
    bl = '{4'd15, 4'd1, 4'd0, 4'd1};
    exp_q = {};
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b10101);
    for (int i = 0; i < 14; i++) exp_q.push_back(5'b10100);
    exp_q.push_back(5'b10110);
    exp_q.push_back(5'b01101);
    exp_q.push_back(5'b01110);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b00101);
    exp_q.push_back(5'b00111);
    exp_q.push_back(5'b00001);
    idx = 0;
    drive(bm[0], bl[0]);
    foreach (exp_q[i]) begin
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 4) drive(bm[idx], bl[idx]);
        else cmd_valid = 1'b0;
      end
      chk($sformatf("bp%0d", i), outv, exp_q[i]);
    end
    chk("bp_accepted", idx, 4);
    cmd_valid = 1'b0;
    step();

    // Reset in cycle 2 of a len 7 command with two commands queued.
    drive(2'd1, 4'd7);
    step();
    drive(2'd2, 4'd1);
    step();
    drive(2'd3, 4'd1);
    step();
    cmd_valid = 1'b0;
    chk("mid_pre", outv, 5'b10100);
    rst = 1'b1;
    #1;
    chk("mid_async", outv, 5'b00001);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk($sformatf("mid_post%0d", i), outv, 5'b00001);
    end

    // Pointer wrap: 10 random commands streamed with valid held high.
    sexp = {};
    ncyc = 3;
    for (int i = 0; i < 10; i++) begin
      rm[i] = 2'($urandom_range(0, 3));
      rl[i] = 4'($urandom_range(0, 5));
      for (int k = 0; k <= int'(rl[i]); k++)
        sexp.push_back({rm[i][0], rm[i][1], 1'b1, (k == int'(rl[i]))});
      ncyc += int'(rl[i]) + 1;
    end
    idx = 0;
    drive(rm[0], rl[0]);
    for (int c = 0; c < ncyc; c++) begin
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 10) drive(rm[idx], rl[idx]);
        else cmd_valid = 1'b0;
      end
      want = (c >= 1 && (c - 1) < sexp.size()) ? sexp[c-1] : 4'b0000;
      chk($sformatf("wrap%0d", c), outv[4:1], want);
    end
    chk("wrap_accepted", idx, 10);
    cmd_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sel_sequencer.md
# sel_sequencer

Command-driven sequencer that produces the `sel1`/`sel2` priority-select pair consumed by the downstream when/case select stage. It accepts timed select commands over a valid/ready handshake and buffers them in a small FIFO. It drives each command's select pattern for a programmed number of cycles, back-to-back with no idle gap, and holds both selects low when idle. This lets the downstream stage fall to its default branch (`foo`=2, `bar`=4).

## Interface
- `CNT_W`, default 4: width of the command length field.
- `DEPTH`, default 2: command FIFO depth; must be a power of two and ≥ 2.

- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_mode`  in  2  select pattern: 0 = none, 1 = sel1, 2 = sel2, 3 = both.
- `cmd_len`  in  CNT_W  hold length minus one.
- `sel1`  out  1  registered select 1 to the downstream stage.
- `sel2`  out  1  registered select 2 to the downstream stage.
- `busy`  out  1  high while a command is being played out.
- `done`  out  1  one-cycle pulse in the final cycle of each command.

## Operation
- **Accept:** a command is accepted on a rising edge where `cmd_valid && cmd_ready`. It is written to the FIFO tail.
- **No pass-through:** a full FIFO deasserts `cmd_ready` even if a pop occurs in the same cycle.
- **FSM states:** IDLE and PLAY.
  - **IDLE:** if the FIFO is non-empty, pop the head, load `cnt` := `cmd_len`, register `sel1`/`sel2` from `cmd_mode`, and go to PLAY. Otherwise keep `sel1`=`sel2`=0.
  - **PLAY, `cnt`≠0:** decrement `cnt`; selects hold.
  - **PLAY, `cnt`=0:** this is the final cycle, so `done`=1.
    - If the FIFO is non-empty at the next edge, pop it, reload `cnt` and the selects, and stay in PLAY. There is no gap cycle.
    - Otherwise clear both selects and return to IDLE.
- **Mode 0 ("none"):** still occupies `cmd_len`+1 cycles with both selects low. It is used as a timed default/gap.
- **Mode 3:** drives both selects high; the downstream stage resolves priority in favour of `sel1`.
- **Duration:** each command drives its pattern for exactly `cmd_len`+1 cycles, so `cmd_len`=0 gives 1 cycle and the maximum is 2^CNT_W cycles.
- **Output flags:** `busy` = (state == PLAY). `done` is combinational from state and `cnt`==0.
- **FIFO pointers:** CNT-free, using log2(DEPTH)+1-bit read/write pointers.
  - Full when the MSBs differ and the rest are equal.
  - Empty when the pointers are equal.
  - Pointers wrap naturally.
- **Reset:** asserting `rst` at any time, including mid-command, immediately clears the FIFO, `cnt`, selects and state. In-flight and queued commands are discarded.

## Timing
- **Reset values:** `sel1`=0, `sel2`=0, `busy`=0, `done`=0, `cmd_ready`=1 (FIFO empty), state = IDLE.
- **Latency:** a command accepted at edge t0 is popped at edge t1. `sel1`/`sel2`/`busy` are high from t1 through the cycle ending at t1+`cmd_len`+1, and `done` is high in that final cycle.
- **Back-to-back:** when the next command is already queued, its selects take effect at the edge ending the previous command's `done` cycle, with zero dead cycles.
- **Simultaneous push and pop, FIFO not full:** both occur and the occupancy is unchanged.
- **Empty FIFO while in PLAY:** a command accepted at the final-cycle edge is not seen until IDLE. This gives one idle cycle with selects low.
- **Hold rule:** `cmd_mode` and `cmd_len` are sampled only at the accepting edge. Upstream must hold them stable while `cmd_valid` is high and `cmd_ready` is low.

## Structure
- **Package `sel_seq_pkg`:**
  - `mode_t` enum: NONE = 0, SEL1 = 1, SEL2 = 2, BOTH = 3.
  - `state_t` enum: IDLE, PLAY.
  - A `cmd_t` struct {mode, len}.
- **Sub-module `sync_fifo`:** parameterised by width and DEPTH, with push/pop/full/empty and a registered head. It is instantiated once with width 2+CNT_W.
- **Top level:** contains the FSM, counter and output registers.

## Test plan
- **Reset:** release `rst`, apply no commands → `sel1`=`sel2`=0, `busy`=0, `cmd_ready`=1 for 20 cycles.
- **Single command:** one command mode=1, len=3 → `sel1` high for exactly 4 cycles starting 1 edge after acceptance; `done` pulses once in the 4th cycle; `busy` falls after it.
- **Back-to-back:** queue mode=2/len=0, then mode=3/len=1, then mode=0/len=2 → `sel2` for 1 cycle, then both high for 2 cycles, then both low with `busy`=1 for 3 cycles; no gaps; three `done` pulses.
- **Backpressure:** hold `cmd_valid` high with DEPTH=2 while the first command plays with len=15 → `cmd_ready` drops after 2 queued entries; no command is lost or duplicated; order is preserved.
- **Reset mid-command:** assert `rst` in cycle 2 of a len=7 command with 2 queued commands → outputs go to 0 immediately; after release, no further selects appear.
- **Pointer wrap:** stream 10 random commands through DEPTH=2 → selects match a scoreboard model cycle-for-cycle across pointer wrap.
